clock_set_ctrl: RTL and testbench

Mode and setting controller for the real-time clock timekeeping datapath. Takes raw mode/increment pushbuttons and debounces them. Sequences the clock through RUN, SET_HR and SET_MIN, and drives one-cycle increment strobes, a run enable, a seconds-clear strobe and a display blink flag to the counter and display blocks.

---
 rtl/clock_set_ctrl_if.sv | 22 ++
 rtl/clock_set_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// Pushbutton inputs and timekeeping control strobes exchanged between
// clock_set_ctrl (slave) and its environment (master).
interface clock_set_ctrl_if;
    logic       btn_mode_i;
    logic       btn_inc_i;
    logic       run_en_o;
    logic       inc_hr_o;
    logic       inc_min_o;
    logic       clr_sec_o;
    logic [1:0] mode_o;
    logic       blink_o;

    modport master (
        output btn_mode_i, btn_inc_i,
        input  run_en_o, inc_hr_o, inc_min_o, clr_sec_o, mode_o, blink_o
    );

    modport slave (
        input  btn_mode_i, btn_inc_i,
        output run_en_o, inc_hr_o, inc_min_o, clr_sec_o, mode_o, blink_o
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// RTC mode/setting controller: debounces the mode and inc buttons and sequences RUN,
// SET_HR and SET_MIN. Build option AUTO_REPEAT_EN adds hold-to-repeat on the inc button.
module clock_set_ctrl #(
    parameter int DEB_CYCLES     = 2000,
    parameter int REPEAT_DELAY   = 20000,
    parameter int REPEAT_RATE    = 8000,
    parameter int TIMEOUT_CYCLES = 400000,
    parameter int BLINK_CYCLES   = 10000,
    parameter int CNT_W          = 20
) (
    input logic             div_clk,
    input logic             rst_i,
    clock_set_ctrl_if.slave ctl
);
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_SET_HR  = 2'd1,
        S_SET_MIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [1:0]       btn_raw;
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       deb_lvl;
    logic [1:0]       deb_lvl_q;
    logic [CNT_W-1:0] deb_cnt [2];
    logic             press_mode;
    logic             press_inc;
    logic             rpt_pulse;

    state_t           state;
    state_t           state_nxt;
    logic             state_chg;
    logic             timeout;
    logic             inc_evt;

    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_d;
    logic [CNT_W-1:0] blink_cnt;
    logic [CNT_W-1:0] blink_cnt_d;
    logic             blink_q;
    logic             blink_d;
    logic             run_en_q;
    logic             run_en_d;
    logic             clr_sec_q;
    logic             clr_sec_d;
    logic             inc_hr_q;
    logic             inc_hr_d;
    logic             inc_min_q;
    logic             inc_min_d;

    // Bit 0 carries the mode button, bit 1 the inc button.
    assign btn_raw = {ctl.btn_inc_i, ctl.btn_mode_i};

    // Synchronizer stages p0/p1, then a level debouncer per button.
    always_ff @(posedge div_clk or negedge rst_i) begin
        if (!rst_i) begin
            sync_p0    <= '0;
            sync_p1    <= '0;
            deb_lvl    <= '0;
            deb_lvl_q  <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync_p0   <= btn_raw;
            sync_p1   <= sync_p0;
            deb_lvl_q <= deb_lvl;
            for (int b = 0; b < 2; b++) begin
                if (sync_p1[b] == deb_lvl[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DEB_LAST) begin
                    deb_lvl[b] <= sync_p1[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign press_mode = deb_lvl[0] & ~deb_lvl_q[0];
    assign press_inc  = deb_lvl[1] & ~deb_lvl_q[1];

    assign state_chg = (state_nxt != state);
    assign timeout   = (state != S_RUN) && (idle_cnt == IDLE_LAST);
    // A mode press or timeout in the same cycle swallows the inc event.
    assign inc_evt   = (state != S_RUN) && !state_chg && (press_inc || rpt_pulse);

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    logic             rpt_armed;
    logic             rpt_first;
    logic [CNT_W-1:0] rpt_cnt;

    assign rpt_pulse = rpt_armed && deb_lvl[1] &&
                       (rpt_cnt == (rpt_first ? RPT_DLY_LAST : RPT_RATE_LAST));

    // Only a press accepted in the current set state arms the repeat.
    always_ff @(posedge div_clk or negedge rst_i) begin
        if (!rst_i) begin
            rpt_armed <= 1'b0;
            rpt_first <= 1'b0;
            rpt_cnt   <= '0;
        end else if (state_chg || !deb_lvl[1]) begin
            rpt_armed <= 1'b0;
            rpt_first <= 1'b0;
            rpt_cnt   <= '0;
        end else if (inc_evt && press_inc) begin
            rpt_armed <= 1'b1;
            rpt_first <= 1'b1;
            rpt_cnt   <= '0;
        end else if (rpt_pulse) begin
            rpt_first <= 1'b0;
            rpt_cnt   <= '0;
        end else if (rpt_armed) begin
            rpt_cnt   <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    always_ff @(posedge div_clk or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_RUN;
            idle_cnt  <= '0;
            blink_cnt <= '0;
            blink_q   <= 1'b0;
            run_en_q  <= 1'b1;
            clr_sec_q <= 1'b0;
            inc_hr_q  <= 1'b0;
            inc_min_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            idle_cnt  <= idle_d;
            blink_cnt <= blink_cnt_d;
            blink_q   <= blink_d;
            run_en_q  <= run_en_d;
            clr_sec_q <= clr_sec_d;
            inc_hr_q  <= inc_hr_d;
            inc_min_q <= inc_min_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:     if (press_mode) state_nxt = S_SET_HR;
            S_SET_HR:  if (press_mode) state_nxt = S_SET_MIN;
                       else if (timeout) state_nxt = S_RUN;
            S_SET_MIN: if (press_mode || timeout) state_nxt = S_RUN;
            default:   state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        run_en_d    = (state_nxt == S_RUN);
        clr_sec_d   = (state == S_RUN) && (state_nxt == S_SET_HR);
        inc_hr_d    = inc_evt && (state == S_SET_HR);
        inc_min_d   = inc_evt && (state == S_SET_MIN);
        idle_d      = idle_cnt + 1'b1;
        blink_cnt_d = blink_cnt + 1'b1;
        blink_d     = blink_q;
        if (state_chg || state == S_RUN || press_mode || press_inc || rpt_pulse) begin
            idle_d = '0;
        end
        if (state_chg || state_nxt == S_RUN) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    assign ctl.run_en_o  = run_en_q;
    assign ctl.clr_sec_o = clr_sec_q;
    assign ctl.inc_hr_o  = inc_hr_q;
    assign ctl.inc_min_o = inc_min_q;
    assign ctl.mode_o    = state;
    assign ctl.blink_o   = blink_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: an event-level model predicts every output each cycle,
// and directed scenarios pin literal timings and pulse counts.
module tb_clock_set_ctrl;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 5;
    localparam int TO  = 50;
    localparam int BL  = 3;

    logic div_clk = 1'b0;
    logic rst_i   = 1'b0;
    clock_set_ctrl_if ifc ();

    clock_set_ctrl #(
        .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
        .TIMEOUT_CYCLES(TO), .BLINK_CYCLES(BL), .CNT_W(20)
    ) dut (
        .div_clk(div_clk),
        .rst_i  (rst_i),
        .ctl    (ifc.slave)
    );

    always #5 div_clk = ~div_clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int cnt_hr      = 0;
    int cnt_min     = 0;
    int cnt_clr     = 0;
    int min_t[$];

    // Model state: raw sample history, debounced levels, mode and event times.
    bit hist_m[$];
    bit hist_i[$];
    bit md_deb, mi_deb, p_mode, p_inc;
    int n, m_mode, m_entry, m_last, m_next;
    bit m_armed;
    bit e_run, e_hr, e_min, e_clr, e_blink;
    int e_mode;

    function automatic bit settled(input bit q[$], input bit lvl);
        for (int k = 0; k < DEB; k++)
            if (q[q.size() - 3 - k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist_m.delete();
        hist_i.delete();
        for (int k = 0; k < DEB + 2; k++) begin
            hist_m.push_back(1'b0);
            hist_i.push_back(1'b0);
        end
        md_deb = 0; mi_deb = 0; p_mode = 0; p_inc = 0;
        n = 0; m_mode = 0; m_entry = 0; m_last = 0; m_next = 0; m_armed = 0;
        e_run = 1; e_hr = 0; e_min = 0; e_clr = 0; e_blink = 0; e_mode = 0;
    endtask

    task automatic model_step(input bit rm, input bit ri);
        int idle_before;
        bit rpt;
        bit nm, ni;
        n++;
        idle_before = n - 1 - m_last;
        rpt = 1'b0;
`ifdef AUTO_REPEAT_EN
        if (m_armed && mi_deb && n == m_next) rpt = 1'b1;
`endif
        if (!mi_deb) m_armed = 1'b0;
        e_clr = 0; e_hr = 0; e_min = 0;
        if (p_mode) begin
            if (m_mode == 0) e_clr = 1;
            m_mode  = (m_mode + 1) % 3;
            m_entry = n;
            m_last  = n;
            m_armed = 0;
        end else if (m_mode != 0 && idle_before == TO - 1) begin
            m_mode  = 0;
            m_armed = 0;
        end else if (m_mode != 0 && (p_inc || rpt)) begin
            if (m_mode == 1) e_hr = 1; else e_min = 1;
            m_last = n;
            if (p_inc) begin
                m_armed = 1;
                m_next  = n + RD;
            end else begin
                m_next  = n + RR;
            end
        end
        e_mode  = m_mode;
        e_run   = (m_mode == 0);
        e_blink = (m_mode != 0) ? bit'(((n - m_entry) / BL) % 2) : 1'b0;

        hist_m.push_back(rm);
        hist_i.push_back(ri);
        if (hist_m.size() > DEB + 4) begin
            void'(hist_m.pop_front());
            void'(hist_i.pop_front());
        end
        nm = settled(hist_m, md_deb) ? ~md_deb : md_deb;
        ni = settled(hist_i, mi_deb) ? ~mi_deb : mi_deb;
        p_mode = nm & ~md_deb;
        p_inc  = ni & ~mi_deb;
        md_deb = nm;
        mi_deb = ni;
    endtask

    always @(posedge div_clk or negedge rst_i) begin
        if (!rst_i) model_reset();
        else        model_step(ifc.btn_mode_i, ifc.btn_inc_i);
    end

    always @(posedge div_clk) cyc++;

    // Per-cycle comparison against the model plus pulse bookkeeping.
    always @(negedge div_clk) begin
        if (rst_i) begin
            vectors++;
            if (ifc.mode_o !== 2'(e_mode) || ifc.run_en_o !== e_run || ifc.inc_hr_o !== e_hr ||
                ifc.inc_min_o !== e_min || ifc.clr_sec_o !== e_clr || ifc.blink_o !== e_blink) begin
                miscompares++;
                $display("FAIL model cycle %0d: dut mode=%0d run=%b hr=%b min=%b clr=%b blink=%b, model mode=%0d run=%b hr=%b min=%b clr=%b blink=%b",
                         cyc, ifc.mode_o, ifc.run_en_o, ifc.inc_hr_o, ifc.inc_min_o, ifc.clr_sec_o, ifc.blink_o,
                         e_mode, e_run, e_hr, e_min, e_clr, e_blink);
            end
            if (ifc.inc_hr_o) cnt_hr++;
            if (ifc.inc_min_o) begin
                cnt_min++;
                min_t.push_back(cyc);
            end
            if (ifc.clr_sec_o) cnt_clr++;
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge div_clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input bit is_inc, input int hi, input int lo);
        if (is_inc) ifc.btn_inc_i = 1'b1; else ifc.btn_mode_i = 1'b1;
        tick(hi);
        if (is_inc) ifc.btn_inc_i = 1'b0; else ifc.btn_mode_i = 1'b0;
        tick(lo);
    endtask

    task automatic clear_counts();
        cnt_hr = 0; cnt_min = 0; cnt_clr = 0;
        min_t.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int k, toggles, prev_blink, t0;
        int exp_off[$];
        ifc.btn_mode_i = 1'b0;
        ifc.btn_inc_i  = 1'b0;
        rst_i = 1'b0;
        tick(3);
        check("reset mode_o", ifc.mode_o, 0);
        check("reset run_en_o", ifc.run_en_o, 1);
        check("reset strobes", {ifc.inc_hr_o, ifc.inc_min_o, ifc.clr_sec_o, ifc.blink_o}, 0);
        rst_i = 1'b1;

        // Idle after reset.
        tick(100);
        check("idle mode_o", ifc.mode_o, 0);
        check("idle run_en_o", ifc.run_en_o, 1);
        check("idle outputs", {ifc.inc_hr_o, ifc.inc_min_o, ifc.clr_sec_o, ifc.blink_o}, 0);

        // Bouncy mode press: two 2-cycle glitches, then stable high.
        clear_counts();
        ifc.btn_mode_i = 1; tick(2);
        ifc.btn_mode_i = 0; tick(1);
        ifc.btn_mode_i = 1; tick(2);
        ifc.btn_mode_i = 0; tick(1);
        ifc.btn_mode_i = 1;
        tick(6);
        check("bounce mode before latency", ifc.mode_o, 0);
        tick(1);
        check("bounce mode at latency 7", ifc.mode_o, 1);
        check("bounce clr_sec pulse", ifc.clr_sec_o, 1);
        check("bounce run_en low", ifc.run_en_o, 0);
        tick(1);
        check("clr_sec one cycle", ifc.clr_sec_o, 0);
        ifc.btn_mode_i = 0;
        tick(10);
        check("single transition", ifc.mode_o, 1);
        check("clr_sec count", cnt_clr, 1);

        // Hour and minute setting.
        clear_counts();
        for (int i = 0; i < 3; i++) press(1'b1, 6, 8);
        check("inc_hr pulses", cnt_hr, 3);
        check("inc_min in SET_HR", cnt_min, 0);
        press(1'b0, 6, 10);
        check("mode to SET_MIN", ifc.mode_o, 2);
        clear_counts();
        for (int i = 0; i < 2; i++) press(1'b1, 6, 8);
        check("inc_min pulses", cnt_min, 2);
        check("inc_hr in SET_MIN", cnt_hr, 0);
        press(1'b0, 6, 10);
        check("mode back to RUN", ifc.mode_o, 0);
        check("run_en in RUN", ifc.run_en_o, 1);

        // Idle timeout and blink cadence.
        ifc.btn_mode_i = 1;
        tick(7);
        check("timeout entry", ifc.mode_o, 1);
        ifc.btn_mode_i = 0;
        toggles = 0;
        prev_blink = 0;
        k = 0;
        while (k <= 60) begin
            tick(1);
            k++;
            if (k == 2) check("blink k=2", ifc.blink_o, 0);
            if (k == 3) check("blink k=3", ifc.blink_o, 1);
            if (int'(ifc.blink_o) != prev_blink) toggles++;
            prev_blink = int'(ifc.blink_o);
            if (ifc.mode_o == 2'd0) break;
        end
        check("timeout cycles", k, TO);
        check("blink toggles", toggles, 16);
        check("blink after timeout", ifc.blink_o, 0);

        // Simultaneous mode and inc press in SET_HR.
        press(1'b0, 6, 10);
        check("enter SET_HR", ifc.mode_o, 1);
        clear_counts();
        ifc.btn_mode_i = 1; ifc.btn_inc_i = 1;
        tick(6);
        ifc.btn_mode_i = 0; ifc.btn_inc_i = 0;
        tick(10);
        check("simul mode_o", ifc.mode_o, 2);
        check("simul inc_hr", cnt_hr, 0);
        check("simul inc_min", cnt_min, 0);
        press(1'b0, 6, 10);
        check("simul back to RUN", ifc.mode_o, 0);

        // Held inc in SET_MIN.
        press(1'b0, 6, 10);
        press(1'b0, 6, 10);
        check("enter SET_MIN", ifc.mode_o, 2);
        clear_counts();
        ifc.btn_inc_i = 1;
        t0 = cyc;
        tick(30);
        ifc.btn_inc_i = 0;
        tick(15);
`ifdef AUTO_REPEAT_EN
        exp_off = '{0, 10, 15, 20, 25};
`else
        exp_off = '{0};
`endif
        check("hold pulse count", min_t.size(), exp_off.size());
        if (min_t.size() > 0) check("hold first latency", min_t[0] - t0, 7);
        for (int i = 0; i < exp_off.size() && i < min_t.size(); i++)
            check("hold pulse offset", min_t[i] - min_t[0], exp_off[i]);

        // Reset while inc is held in a set state.
        ifc.btn_inc_i = 1;
        tick(9);
        rst_i = 0;
        #1;
        check("midpress reset mode", ifc.mode_o, 0);
        check("midpress reset run_en", ifc.run_en_o, 1);
        check("midpress reset inc_min", ifc.inc_min_o, 0);
        tick(2);
        rst_i = 1;
        tick(12);
        ifc.btn_inc_i = 0;
        tick(12);
        check("post reset stays RUN", ifc.mode_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
